// File: rtl/wave_gen.sv
// wave_gen: multi-mode periodic waveform generator (saw-up, ramp-down, triangle, square).
// A prescaler makes a tick every div+1 clocks, and the phase accumulator advances by step on each tick.
// mode/div/step are shadowed and reloaded only at a period boundary or on sync, so changes never glitch.
// Optional build macro WAVE_GEN_AMPL_EN adds an amplitude stage: val = (raw*amp) >> WIDTH,
// which adds one clock of latency; wrap is delayed with it.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   en         : run enable (0 holds all state, wrap forced 0)
//   sync       : restart pulse (phase 0, shadows reload)
//   mode       : 0 saw-up, 1 ramp-down, 2 triangle, 3 square
//   div        : tick every div+1 clocks
//   step       : phase increment per tick
//   amp        : amplitude scale (amplitude build only)
//   val        : registered waveform sample
//   wrap       : strobe alongside the first sample of a new period
module wave_gen #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIV_W = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sync,
    input  logic [1:0]       mode,
    input  logic [DIV_W-1:0] div,
    input  logic [WIDTH-1:0] step,
    input  logic [WIDTH-1:0] amp,
    output logic [WIDTH-1:0] val,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX       = '1;
    localparam logic [1:0]       MODE_RAMP = 2'd1;
    localparam logic [1:0]       MODE_TRI  = 2'd2;
    localparam logic [1:0]       MODE_SQR  = 2'd3;

    typedef enum logic {DIR_UP, DIR_DOWN} dir_e;

    logic [DIV_W-1:0] pcnt_q, pcnt_d;
    logic [WIDTH-1:0] phase_q, phase_d;
    dir_e             dir_q, dir_d;
    logic [1:0]       mode_s_q, mode_s_d;
    logic [DIV_W-1:0] div_s_q, div_s_d;
    logic [WIDTH-1:0] step_s_q, step_s_d;
    logic [WIDTH-1:0] val_q, val_d;
    logic             wrap_q, wrap_d;
    logic             bnd_q, bnd_d;

    logic             tick;
    logic             boundary;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] adv_phase;
    dir_e             adv_dir;
    logic [WIDTH-1:0] sample;

    // Phase advance for one tick; boundary is the saw carry-out or the triangle return to 0
    always_comb begin
        tick      = (pcnt_q == div_s_q);
        sum       = {1'b0, phase_q} + {1'b0, step_s_q};
        adv_phase = sum[WIDTH-1:0];
        adv_dir   = dir_q;
        boundary  = 1'b0;
        if (mode_s_q == MODE_TRI) begin
            if (dir_q == DIR_UP) begin
                if (phase_q > (MAX - step_s_q)) begin
                    adv_phase = MAX;
                    adv_dir   = DIR_DOWN;
                end
            end else if (phase_q < step_s_q) begin
                adv_phase = '0;
                adv_dir   = DIR_UP;
                boundary  = 1'b1;
            end else begin
                adv_phase = phase_q - step_s_q;
            end
        end else begin
            boundary = sum[WIDTH];
        end
    end

    // Map the current phase to an output sample using the shadowed mode
    always_comb begin
        case (mode_s_q)
            MODE_RAMP: sample = ~phase_q;
            MODE_SQR:  sample = phase_q[WIDTH-1] ? MAX : '0;
            default:   sample = phase_q;
        endcase
    end

    // Next state: sync restarts, en runs; bnd_q carries the boundary to the cycle its sample appears
    always_comb begin
        pcnt_d   = pcnt_q;
        phase_d  = phase_q;
        dir_d    = dir_q;
        mode_s_d = mode_s_q;
        div_s_d  = div_s_q;
        step_s_d = step_s_q;
        val_d    = val_q;
        bnd_d    = bnd_q;
        wrap_d   = 1'b0;
        if (sync) begin
            pcnt_d   = '0;
            phase_d  = '0;
            dir_d    = DIR_UP;
            mode_s_d = mode;
            div_s_d  = div;
            step_s_d = step;
            val_d    = '0;
            bnd_d    = 1'b0;
        end else if (en) begin
            val_d  = sample;
            wrap_d = bnd_q;
            bnd_d  = 1'b0;
            if (tick) begin
                pcnt_d  = '0;
                phase_d = adv_phase;
                dir_d   = adv_dir;
                if (boundary) begin
                    bnd_d    = 1'b1;
                    dir_d    = DIR_UP;
                    mode_s_d = mode;
                    div_s_d  = div;
                    step_s_d = step;
                end
            end else begin
                pcnt_d = pcnt_q + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pcnt_q   <= '0;
            phase_q  <= '0;
            dir_q    <= DIR_UP;
            mode_s_q <= mode;
            div_s_q  <= div;
            step_s_q <= step;
            val_q    <= '0;
            wrap_q   <= 1'b0;
            bnd_q    <= 1'b0;
        end else begin
            pcnt_q   <= pcnt_d;
            phase_q  <= phase_d;
            dir_q    <= dir_d;
            mode_s_q <= mode_s_d;
            div_s_q  <= div_s_d;
            step_s_q <= step_s_d;
            val_q    <= val_d;
            wrap_q   <= wrap_d;
            bnd_q    <= bnd_d;
        end
    end

`ifdef WAVE_GEN_AMPL_EN
    localparam int unsigned PW = 2 * WIDTH;

    logic [WIDTH-1:0] aval_q, aval_d;
    logic             awrap_q, awrap_d;
    logic [PW-1:0]    prod;

    // Amplitude stage: upper half of the full product, truncating
    always_comb begin
        prod    = PW'(val_q) * PW'(amp);
        aval_d  = aval_q;
        awrap_d = 1'b0;
        if (sync) begin
            aval_d = '0;
        end else if (en) begin
            aval_d  = prod[PW-1:WIDTH];
            awrap_d = wrap_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            aval_q  <= '0;
            awrap_q <= 1'b0;
        end else begin
            aval_q  <= aval_d;
            awrap_q <= awrap_d;
        end
    end

    assign val  = aval_q;
    assign wrap = awrap_q;
`else
    logic unused_amp;
    assign unused_amp = ^amp;

    assign val  = val_q;
    assign wrap = wrap_q;
`endif

endmodule
